// File: rtl/data_mem_lsu_pkg.sv
// Shared encodings and defaults for the data-memory load/store controller.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DEF_OFFSET = 256;
  localparam int unsigned DEF_DEPTH  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_RESP
  } lsu_state_t;

  // Reserved size or a lane that does not match the access size.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] lane);
    bad_shape = (size == 2'b11) ||
                ((size == SZ_HALF) && lane[0]) ||
                ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response handshake plus the word-wide data memory port.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_data_out;

  // The LSU itself.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_data_in, mem_we, mem_re
  );

  // The CPU datapath together with the memory.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_data_in, mem_we, mem_re
  );
endinterface

// File: rtl/data_mem_lsu_lane.sv
// Lane extraction with sign/zero extension for loads and lane merge for sub-word stores.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  sh;
  logic [31:0] rshift;
  logic [31:0] mask;
  logic [31:0] wshift;

  always_comb begin
    sh      = {lane, 3'b000};
    rshift  = rword >> sh;
    wshift  = wdata << sh;
    ld_data = rword;
    mask    = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{sgn & rshift[7]}}, rshift[7:0]};
        mask    = 32'h0000_00FF << sh;
      end
      SZ_HALF: begin
        ld_data = {{16{sgn & rshift[15]}}, rshift[15:0]};
        mask    = 32'h0000_FFFF << sh;
      end
      default: begin
        ld_data = rword;
        mask    = 32'hFFFF_FFFF;
      end
    endcase
    // Only the addressed lane(s) of the old word are replaced.
    st_word = (rword & ~mask) | (wshift & mask);
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed load/store controller driving a word-indexed synchronous data memory.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned OFFSET = DEF_OFFSET,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_lsu_if.slave    bus
);

  localparam int unsigned LAST_I = OFFSET + DEPTH - 1;
  localparam logic [29:0] LO_IDX = OFFSET[29:0];
  localparam logic [29:0] HI_IDX = LAST_I[29:0];

  lsu_state_t  state;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;

  logic        we_p0;
  logic [1:0]  size_p0;
  logic        sgn_p0;
  logic [1:0]  lane_p0;
  logic [29:0] widx_p0;
  logic [31:0] wdata_p0;
  logic [31:0] wbuf_p1;

  logic [29:0] req_widx;
  logic        req_fault;
  logic        accept;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign req_widx  = bus.req_addr[31:2];
  assign req_fault = (req_widx < LO_IDX) || (req_widx > HI_IDX) ||
                     bad_shape(bus.req_size, bus.req_addr[1:0]);
  assign accept    = bus.req_valid && bus.req_ready;

  lsu_lane u_lane (
    .size    (size_p0),
    .lane    (lane_p0),
    .sgn     (sgn_p0),
    .rword   (bus.mem_data_out),
    .wdata   (wdata_p0),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Control: state and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (req_fault) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
            end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD:   state <= ST_WAIT;
        ST_WAIT: begin
          if (we_p0) begin
            state <= ST_WR;
          end else begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= ld_data;
          end
        end
        ST_WR: begin
          state        <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data: latched request fields and the write buffer.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      size_p0  <= bus.req_size;
      sgn_p0   <= bus.req_signed;
      lane_p0  <= bus.req_addr[1:0];
      widx_p0  <= req_widx;
      wdata_p0 <= bus.req_wdata;
      wbuf_p1  <= bus.req_wdata;
    end else if ((state == ST_WAIT) && we_p0) begin
      wbuf_p1 <= st_word;
    end
  end

  assign bus.req_ready   = (state == ST_IDLE) && !rst;
  assign bus.mem_re      = (state == ST_RD) && !rst;
  assign bus.mem_we      = (state == ST_WR) && !rst;
  assign bus.mem_addr    = (!rst && ((state == ST_RD) || (state == ST_WAIT) || (state == ST_WR)))
                           ? {2'b00, widx_p0} : '0;
  assign bus.mem_data_in = bus.mem_we ? wbuf_p1 : '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_fault  = resp_fault_q;
  assign bus.resp_rdata  = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a small behavioural word memory.
module tb_data_mem_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  data_mem_lsu_if bus ();

  data_mem_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[10:0]] <= bus.mem_data_in;
    if (bus.mem_re) bus.mem_data_out <= mem[bus.mem_addr[10:0]];
  end

  int          obs_lat, obs_re, obs_we, obs_we_lat;
  logic [31:0] obs_we_addr, obs_we_data, obs_rdata;
  logic        obs_fault;

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    obs_lat = 99; obs_re = 0; obs_we = 0; obs_we_lat = 0;
    obs_we_addr = '0; obs_we_data = '0; obs_rdata = 'x; obs_fault = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      if (bus.mem_re) obs_re++;
      if (bus.mem_we) begin
        obs_we++; obs_we_lat = c; obs_we_addr = bus.mem_addr; obs_we_data = bus.mem_data_in;
      end
      if (bus.resp_valid) begin
        obs_lat = c; obs_rdata = bus.resp_rdata; obs_fault = bus.resp_fault;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.req_ready); end
    total++;
    if ({bus.resp_valid, bus.resp_fault, bus.mem_we, bus.mem_re} !== 4'b0000 ||
        bus.resp_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_data_in !== 32'h0) begin
      bad++;
      $display("FAIL rst_outputs got v=%b f=%b we=%b re=%b rd=%h ma=%h md=%h want all zero",
               bus.resp_valid, bus.resp_fault, bus.mem_we, bus.mem_re,
               bus.resp_rdata, bus.mem_addr, bus.mem_data_in);
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", bus.req_ready); end
  endtask

  task automatic test_word_access;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF);
    total++; if (obs_we_lat !== 1 || obs_we !== 1) begin bad++; $display("FAIL wst_we got lat=%0d n=%0d want lat=1 n=1", obs_we_lat, obs_we); end
    total++; if (obs_we_addr !== 32'd256) begin bad++; $display("FAIL wst_addr got=%0d want=256", obs_we_addr); end
    total++; if (obs_we_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wst_data got=%h want=deadbeef", obs_we_data); end
    total++; if (obs_lat !== 2 || obs_fault !== 1'b0 || obs_re !== 0) begin bad++; $display("FAIL wst_resp got lat=%0d f=%b re=%0d want 2 0 0", obs_lat, obs_fault, obs_re); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0);
    total++; if (obs_lat !== 3 || obs_re !== 1 || obs_we !== 0) begin bad++; $display("FAIL wld_timing got lat=%0d re=%0d we=%0d want 3 1 0", obs_lat, obs_re, obs_we); end
    total++; if (obs_rdata !== 32'hDEAD_BEEF || obs_fault !== 1'b0) begin bad++; $display("FAIL wld_data got=%h f=%b want=deadbeef 0", obs_rdata, obs_fault); end
  endtask

  task automatic test_subword;
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h0000_0401, 32'h5A5A_5AA5);
    total++; if (obs_lat !== 4 || obs_re !== 1 || obs_we !== 1 || obs_we_lat !== 3) begin bad++; $display("FAIL bst_timing got lat=%0d re=%0d we=%0d wlat=%0d want 4 1 1 3", obs_lat, obs_re, obs_we, obs_we_lat); end
    total++; if (obs_we_data !== 32'hDEAD_A5EF || obs_we_addr !== 32'd256) begin bad++; $display("FAIL bst_merge got=%h @%0d want=deada5ef @256", obs_we_data, obs_we_addr); end
    total++; if (obs_rdata !== 32'h0 || obs_fault !== 1'b0) begin bad++; $display("FAIL bst_resp got=%h f=%b want=0 0", obs_rdata, obs_fault); end
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h0000_0401, 32'h0);
    total++; if (obs_rdata !== 32'hFFFF_FFA5 || obs_lat !== 3) begin bad++; $display("FAIL bld_signed got=%h lat=%0d want=ffffffa5 3", obs_rdata, obs_lat); end
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h0000_0401, 32'h0);
    total++; if (obs_rdata !== 32'h0000_00A5) begin bad++; $display("FAIL bld_unsigned got=%h want=000000a5", obs_rdata); end
    do_req(1'b0, SZ_HALF, 1'b1, 32'h0000_0402, 32'h0);
    total++; if (obs_rdata !== 32'hFFFF_DEAD) begin bad++; $display("FAIL hld_signed got=%h want=ffffdead", obs_rdata); end
    do_req(1'b0, SZ_HALF, 1'b0, 32'h0000_0402, 32'h0);
    total++; if (obs_rdata !== 32'h0000_DEAD) begin bad++; $display("FAIL hld_unsigned got=%h want=0000dead", obs_rdata); end
  endtask

  task automatic test_top_word;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_13FC, 32'hCAFE_F00D);
    total++; if (obs_lat !== 2 || obs_fault !== 1'b0 || obs_we_addr !== 32'd1279) begin bad++; $display("FAIL top_wst got lat=%0d f=%b a=%0d want 2 0 1279", obs_lat, obs_fault, obs_we_addr); end
    do_req(1'b1, SZ_HALF, 1'b0, 32'h0000_13FE, 32'h0000_BEEF);
    total++; if (obs_we_data !== 32'hBEEF_F00D || obs_lat !== 4) begin bad++; $display("FAIL top_hst got=%h lat=%0d want=beeff00d 4", obs_we_data, obs_lat); end
  endtask

  task automatic test_faults;
    logic        f_we  [5];
    logic [1:0]  f_sz  [5];
    logic [31:0] f_adr [5];
    f_we[0] = 1'b0; f_sz[0] = SZ_WORD; f_adr[0] = 32'h0000_0402;
    f_we[1] = 1'b1; f_sz[1] = SZ_HALF; f_adr[1] = 32'h0000_0401;
    f_we[2] = 1'b0; f_sz[2] = 2'b11;   f_adr[2] = 32'h0000_0400;
    f_we[3] = 1'b0; f_sz[3] = SZ_WORD; f_adr[3] = 32'h0000_03FC;
    f_we[4] = 1'b1; f_sz[4] = SZ_WORD; f_adr[4] = 32'h0000_1400;
    for (int i = 0; i < 5; i++) begin
      // A successful load first leaves non-zero data in resp_rdata.
      do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0);
      do_req(f_we[i], f_sz[i], 1'b1, f_adr[i], 32'h1234_5678);
      total++;
      if (obs_lat !== 1 || obs_fault !== 1'b1 || obs_rdata !== 32'h0 || obs_re !== 0 || obs_we !== 0) begin
        bad++;
        $display("FAIL fault_%0d got lat=%0d f=%b rd=%h re=%0d we=%0d want 1 1 0 0 0",
                 i, obs_lat, obs_fault, obs_rdata, obs_re, obs_we);
      end
    end
  endtask

  task automatic test_reset_midway;
    int we_cnt, rv_cnt;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0404, 32'h1122_3344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0000_0405; bus.req_wdata = 32'h0000_0077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", bus.req_ready); end
    we_cnt = 0; rv_cnt = 0;
    if (bus.mem_we) we_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.mem_we) we_cnt++;
      if (bus.resp_valid) rv_cnt++;
      if (c == 1) begin
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%b want=1", bus.req_ready); end
      end
      @(negedge clk);
    end
    total++; if (we_cnt !== 0 || rv_cnt !== 0) begin bad++; $display("FAIL mid_abort got we=%0d resp=%0d want 0 0", we_cnt, rv_cnt); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0404, 32'h0);
    total++; if (obs_rdata !== 32'h1122_3344) begin bad++; $display("FAIL mid_word_kept got=%h want=11223344", obs_rdata); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  b_sz  [3];
    logic        b_sg  [3];
    logic [31:0] b_adr [3];
    logic [31:0] b_exp [3];
    int          acc   [3];
    int          re_cyc[$];
    int          rs_cyc[$];
    logic [31:0] rs_dat[$];
    int          idx;
    b_sz[0] = SZ_WORD; b_sg[0] = 1'b0; b_adr[0] = 32'h0000_0400; b_exp[0] = 32'hDEAD_A5EF;
    b_sz[1] = SZ_BYTE; b_sg[1] = 1'b1; b_adr[1] = 32'h0000_0401; b_exp[1] = 32'hFFFF_FFA5;
    b_sz[2] = SZ_HALF; b_sg[2] = 1'b0; b_adr[2] = 32'h0000_0402; b_exp[2] = 32'h0000_DEAD;
    idx = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (bus.mem_re) re_cyc.push_back(c);
      if (bus.resp_valid) begin rs_cyc.push_back(c); rs_dat.push_back(bus.resp_rdata); end
      if (bus.req_ready) begin
        if (idx < 3) begin
          bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = b_sz[idx];
          bus.req_signed = b_sg[idx]; bus.req_addr = b_adr[idx]; bus.req_wdata = '0;
          acc[idx] = c;
          idx++;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    total++; if (idx !== 3) begin bad++; $display("FAIL b2b_accepts got=%0d want=3", idx); end
    if (idx == 3) begin
      total++; if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin bad++; $display("FAIL b2b_ready_period got=%0d,%0d want=4,4", acc[1] - acc[0], acc[2] - acc[1]); end
    end
    total++; if (re_cyc.size() !== 3 || rs_cyc.size() !== 3) begin bad++; $display("FAIL b2b_counts got re=%0d resp=%0d want 3 3", re_cyc.size(), rs_cyc.size()); end
    if (idx == 3 && re_cyc.size() == 3 && rs_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (re_cyc[i] !== acc[i] + 1) begin bad++; $display("FAIL b2b_re_%0d got=%0d want=%0d", i, re_cyc[i], acc[i] + 1); end
        total++; if (rs_cyc[i] !== acc[i] + 3 || rs_dat[i] !== b_exp[i]) begin bad++; $display("FAIL b2b_resp_%0d got c=%0d d=%h want c=%0d d=%h", i, rs_cyc[i], rs_dat[i], acc[i] + 3, b_exp[i]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_word_access();
    test_subword();
    test_top_word();
    test_faults();
    test_reset_midway();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store controller that sits between the CPU datapath and the word-organised synchronous data memory, acting as its sole initiator. It accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. It converts them into word-indexed memory accesses, using read-modify-write for sub-word stores, and returns sign- or zero-extended load data. Misaligned and out-of-range accesses are rejected with a fault and never reach the memory.

## Interface
- OFFSET, 256, first valid word index of data memory
- DEPTH, 1024, number of words in data memory
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (fault)
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  access rejected
- mem_addr  out  32  word index into data memory
- mem_data_in  out  32  write data to memory
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_data_out  in  32  memory read data, valid the cycle after mem_re

## Operation
- Word index = req_addr[31:2]; lane = req_addr[1:0]; little-endian, byte n occupies bits [8n+7:8n].
- Fault when any of the following holds: word index < OFFSET; word index > OFFSET+DEPTH-1; req_size==11; half with addr[0]=1; word with addr[1:0]!=0.
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch all request fields and evaluate fault, then transition:
  - fault -> RESP
  - load -> RD
  - word store -> WR
  - byte/half store -> RD
- RD: mem_re=1 for exactly one cycle; -> WAIT.
- WAIT: mem_data_out is valid.
  - Load: extract the lane, extend per req_signed, register into resp_rdata; -> RESP.
  - Sub-word store: merge the wdata lane(s) into the read word, register it into the write buffer; -> WR.
- WR: mem_we=1 for exactly one cycle, with mem_data_in = write buffer (word store: req_wdata unchanged); -> RESP.
- RESP: resp_valid=1 for one cycle; resp_fault and resp_rdata are held until the next RESP. Then -> IDLE. There is no response backpressure.
- mem_addr holds the latched word index from RD through WR; it is 0 in IDLE, RESP and on fault. mem_data_in is 0 outside WR.
- mem_re and mem_we are decoded from the state and gated by !rst, so neither is asserted in any cycle where rst=1.
- Any request arriving while req_ready=0 is ignored, not queued.

## Timing
- Accept in cycle k (req_valid & req_ready). resp_valid is asserted in cycle:
  - fault: k+1
  - word store: k+2
  - load: k+3
  - sub-word store: k+4
- req_ready returns to 1 in the cycle after RESP.
- Throughput with req_valid held high: one word store every 3 cycles, one load every 4 cycles.
- Reset values: state IDLE; req_ready=0 while rst=1, and 1 in the first cycle after rst deasserts. resp_valid, resp_fault, resp_rdata, mem_addr, mem_data_in, mem_we and mem_re are all 0.
- Reset mid-transaction aborts the transaction: no response is produced, no further memory strobes are issued, and any partially merged write is discarded.

## Structure
- Package lsu_pkg contains:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - default OFFSET/DEPTH constants
- Sub-module lsu_lane (combinational) provides load extraction/extension and store merge, parameterised by size, lane and signed. It is instantiated once, and the FSM selects which result to register.

## Test plan
- Word store 0xDEADBEEF @0x400 -> in cycle k+1, mem_we=1 with mem_addr=256 and mem_data_in=0xDEADBEEF; resp_valid at k+2 with fault=0. A word load @0x400 then returns 0xDEADBEEF at k+3.
- Byte store 0xA5 @0x401 over 0xDEADBEEF -> memory reads 0xDEADA5EF. Signed byte load @0x401 returns 0xFFFFFFA5; unsigned returns 0x000000A5.
- Signed half load @0x402 returns 0xFFFFDEAD; unsigned returns 0x0000DEAD.
- Each of these faults at k+1 with resp_rdata=0 and no mem_re/mem_we: word load @0x402; half @0x401; req_size=11; addresses 0x3FC (word 255) and 0x1400 (word 1280).
- Reset asserted in WAIT of a byte store -> mem_we never asserts and the target word is unchanged. req_ready=1 in the first cycle after release.
- req_valid held high for 3 loads -> req_ready pulses every 4 cycles, each response is correct in order, and mem_re never asserts while in WAIT or RESP.
